// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter, 8 data bits, 1 stop bit
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_wr,
    output logic                          tx_full,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          rs232_tx
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW       = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic          r_full;
    logic          r_busy;
    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
`ifdef UART_TX_PARITY_EN
    logic          r_par;
`endif

    logic          w_push;
    logic          w_pop;
    logic          w_bit_end;
    logic          w_line;
    logic [7:0]    w_head;
    logic [CW-1:0] w_cnt_next;

    // A full FIFO refuses writes even when a pop frees a slot in the same cycle.
    assign w_push     = tx_wr && !r_full;
    assign w_bit_end  = (r_baud == BW'(BAUD_DIV - 1));
    assign w_pop      = (r_cnt != '0) &&
                        ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));
    assign w_head     = r_mem[r_rptr];
    assign w_cnt_next = r_cnt + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_cnt  <= w_cnt_next;
            r_full <= (w_cnt_next == CW'(FIFO_DEPTH));
            r_busy <= w_push || (r_cnt != '0) || (r_state != IDLE);
        end
    end

    // Line level for the current state; registered into r_tx one cycle later.
    always_comb begin
        w_line = 1'b1;
        case (r_state)
            START:   w_line = 1'b0;
            DATA:    w_line = r_shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_line = r_par;
`endif
            default: w_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_tx   <= w_line;
            r_baud <= ((r_state == IDLE) || w_bit_end) ? '0 : r_baud + BW'(1);
            if (w_pop) begin
                r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
                r_par   <= ^w_head;
`endif
            end
            case (r_state)
                IDLE: if (w_pop) r_state <= START;
                START: if (w_bit_end) r_state <= DATA;
                DATA: if (w_bit_end) begin
                    r_shift <= {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        r_bit <= '0;
`ifdef UART_TX_PARITY_EN
                        r_state <= PARITY;
`else
                        r_state <= STOP;
`endif
                    end else begin
                        r_bit <= r_bit + 3'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (w_bit_end) r_state <= STOP;
`endif
                STOP: if (w_bit_end) r_state <= w_pop ? START : IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_full  = r_full;
    assign tx_busy  = r_busy;
    assign fifo_cnt = r_cnt;
    assign rs232_tx = r_tx;
endmodule
